// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// Weight-sequence read controller: walks the weight table seq_len entries per pass, num_rpt passes.
// Optional back-pressure is enabled by defining WHT_SEQ_CTRL_STALL_EN; otherwise stall is ignored.
`ifndef NUM_WHT_SEQ_VALUES
`define NUM_WHT_SEQ_VALUES 5
`endif

module cnn_layer_accel_weight_seq_ctrl #(
  parameter int C_RDADDR_WIDTH = $clog2(`NUM_WHT_SEQ_VALUES),
  parameter int C_RPT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [C_RDADDR_WIDTH:0]   seq_len,
  input  logic [C_RPT_WIDTH-1:0]    num_rpt,
  input  logic                      stall,
  output logic [C_RDADDR_WIDTH-1:0] rdAddr,
  output logic                      rden,
  output logic                      seq_valid,
  output logic                      seq_last,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  localparam logic [C_RDADDR_WIDTH:0]   LEN_MAX   = (C_RDADDR_WIDTH+1)'(`NUM_WHT_SEQ_VALUES);
  localparam logic [C_RDADDR_WIDTH:0]   LEN_ONE   = (C_RDADDR_WIDTH+1)'(1);
  localparam logic [C_RDADDR_WIDTH:0]   LEN_ZERO  = (C_RDADDR_WIDTH+1)'(0);
  localparam logic [C_RPT_WIDTH-1:0]    RPT_ONE   = C_RPT_WIDTH'(1);
  localparam logic [C_RPT_WIDTH-1:0]    RPT_ZERO  = C_RPT_WIDTH'(0);
  localparam logic [C_RDADDR_WIDTH-1:0] ADDR_ONE  = C_RDADDR_WIDTH'(1);
  localparam logic [C_RDADDR_WIDTH-1:0] ADDR_ZERO = C_RDADDR_WIDTH'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [C_RDADDR_WIDTH:0]   seq_len_r;
  logic [C_RPT_WIDTH-1:0]    num_rpt_r;
  logic [C_RDADDR_WIDTH-1:0] addr_r;
  logic [C_RDADDR_WIDTH-1:0] last_addr_r;
  logic [C_RPT_WIDTH-1:0]    pass_r;
  logic                      seq_valid_r;
  logic                      seq_last_r;
  logic                      cfg_err_r;
  logic                      rden_s;
  logic                      stall_eff_s;
  logic                      cfg_bad_s;
  logic                      start_ok_s;
  logic                      addr_last_s;
  logic                      pass_last_s;

`ifdef WHT_SEQ_CTRL_STALL_EN
  assign stall_eff_s = stall;
`else
  logic stall_unused_s;
  assign stall_unused_s = stall;
  assign stall_eff_s    = 1'b0;
`endif

  assign cfg_bad_s   = (seq_len == LEN_ZERO) || (seq_len > LEN_MAX) || (num_rpt == RPT_ZERO);
  assign start_ok_s  = (state_r == IDLE) && start && !cfg_bad_s;
  assign addr_last_s = ({1'b0, addr_r} == (seq_len_r - LEN_ONE));
  assign pass_last_s = (pass_r == (num_rpt_r - RPT_ONE));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and read-issue decode
  always_comb begin
    state_nxt_s = state_r;
    rden_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (!stall_eff_s) begin
          rden_s = 1'b1;
          if (addr_last_s && pass_last_s) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN:   state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Job configuration latch plus address/pass counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_len_r   <= LEN_ZERO;
      num_rpt_r   <= RPT_ZERO;
      addr_r      <= ADDR_ZERO;
      last_addr_r <= ADDR_ZERO;
      pass_r      <= RPT_ZERO;
    end else if (start_ok_s) begin
      seq_len_r <= seq_len;
      num_rpt_r <= num_rpt;
      addr_r    <= ADDR_ZERO;
      pass_r    <= RPT_ZERO;
    end else if (rden_s) begin
      last_addr_r <= addr_r;
      if (addr_last_s) begin
        addr_r <= ADDR_ZERO;
        pass_r <= pass_r + RPT_ONE;
      end else begin
        addr_r <= addr_r + ADDR_ONE;
      end
    end
  end

  // Read-data qualifiers delayed by the table latency, plus config-error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_valid_r <= 1'b0;
      seq_last_r  <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      seq_valid_r <= rden_s;
      seq_last_r  <= rden_s && addr_last_s;
      cfg_err_r   <= (state_r == IDLE) && start && cfg_bad_s;
    end
  end

  // rdAddr holds the last issued address while no read is being made
  assign rdAddr    = rden_s ? addr_r : last_addr_r;
  assign rden      = rden_s;
  assign seq_valid = seq_valid_r;
  assign seq_last  = seq_last_r;
  assign busy      = (state_r != IDLE);
  assign done      = (state_r == DONE);
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
// Directed bench for cnn_layer_accel_weight_seq_ctrl; read addresses checked against a queue of expected values.
module tb_cnn_layer_accel_weight_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  seq_len = 4'd0;
  logic [15:0] num_rpt = 16'd0;
  logic [2:0]  rdAddr;
  logic        rden, seq_valid, seq_last, busy, done, cfg_err;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  logic rden_log [64];
  logic last_log [64];
  logic done_log [64];
  logic cfg_log  [64];
  logic busy_log [64];
  logic [2:0] addr_log [64];
  int n_rden, n_last, n_valid, n_done, n_cfg, n_busy;

  cnn_layer_accel_weight_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seq_len   (seq_len),
    .num_rpt   (num_rpt),
    .stall     (stall),
    .rdAddr    (rdAddr),
    .rden      (rden),
    .seq_valid (seq_valid),
    .seq_last  (seq_last),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a start pulse; legal jobs push their expected address stream.
  task automatic do_start(input int len, input int rpt);
    @(negedge clk);
    seq_len = 4'(len);
    num_rpt = 16'(rpt);
    start   = 1'b1;
    if (len >= 1 && len <= 5 && rpt > 0) begin
      for (int p = 0; p < rpt; p++)
        for (int a = 0; a < len; a++)
          exp_q.push_back(a);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Step n cycles (cycle k = k-th cycle after the start edge), logging outputs.
  task automatic run_cycles(input int n, input int stall_lo, input int stall_hi, input int start_at);
    n_rden = 0; n_last = 0; n_valid = 0; n_done = 0; n_cfg = 0; n_busy = 0;
    for (int k = 1; k <= n; k++) begin
      stall = (k >= stall_lo && k <= stall_hi);
      if (k == start_at) begin
        seq_len = 4'd2;
        num_rpt = 16'd1;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      rden_log[k] = rden;
      last_log[k] = seq_last;
      done_log[k] = done;
      cfg_log[k]  = cfg_err;
      busy_log[k] = busy;
      addr_log[k] = rdAddr;
      n_rden  += int'(rden);
      n_last  += int'(seq_last);
      n_valid += int'(seq_valid);
      n_done  += int'(done);
      n_cfg   += int'(cfg_err);
      n_busy  += int'(busy);
      if (rden) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
        else check("rdAddr", 32'(rdAddr), 32'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rden", 32'(rden), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_rdAddr", 32'(rdAddr), 32'd0);
    check("rst_seq_valid", 32'(seq_valid), 32'd0);
    check("rst_seq_last", 32'(seq_last), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Two passes of five entries
    do_start(5, 2);
    run_cycles(14, 99, 0, 0);
    check("a_first_rden", 32'(rden_log[1]), 32'd1);
    check("a_rden_cnt", 32'(n_rden), 32'd10);
    check("a_rden_10", 32'(rden_log[10]), 32'd1);
    check("a_rden_11", 32'(rden_log[11]), 32'd0);
    check("a_last_6", 32'(last_log[6]), 32'd1);
    check("a_last_11", 32'(last_log[11]), 32'd1);
    check("a_last_cnt", 32'(n_last), 32'd2);
    check("a_valid_cnt", 32'(n_valid), 32'd10);
    check("a_done_12", 32'(done_log[12]), 32'd1);
    check("a_done_cnt", 32'(n_done), 32'd1);
    check("a_busy_1", 32'(busy_log[1]), 32'd1);
    check("a_busy_13", 32'(busy_log[13]), 32'd0);
    check("a_sb_empty", 32'(exp_q.size()), 32'd0);

    // Stall in cycles 2..4
    do_start(5, 1);
    run_cycles(12, 2, 4, 0);
    check("b_rden_cnt", 32'(n_rden), 32'd5);
    check("b_done_cnt", 32'(n_done), 32'd1);
    check("b_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef WHT_SEQ_CTRL_STALL_EN
    check("b_rden_2", 32'(rden_log[2]), 32'd0);
    check("b_rden_5", 32'(rden_log[5]), 32'd1);
    check("b_addr_hold_3", 32'(addr_log[3]), 32'd0);
    check("b_last_9", 32'(last_log[9]), 32'd1);
    check("b_done_10", 32'(done_log[10]), 32'd1);
`else
    check("b_rden_2", 32'(rden_log[2]), 32'd1);
    check("b_rden_5", 32'(rden_log[5]), 32'd1);
    check("b_last_6", 32'(last_log[6]), 32'd1);
    check("b_done_7", 32'(done_log[7]), 32'd1);
`endif

    // Illegal configurations: num_rpt=0, seq_len=6, seq_len=0
    do_start(5, 0);
    run_cycles(4, 99, 0, 0);
    check("c0_cfg_1", 32'(cfg_log[1]), 32'd1);
    check("c0_cfg_cnt", 32'(n_cfg), 32'd1);
    check("c0_rden_cnt", 32'(n_rden), 32'd0);
    check("c0_done_cnt", 32'(n_done), 32'd0);
    check("c0_busy_cnt", 32'(n_busy), 32'd0);
    do_start(6, 1);
    run_cycles(4, 99, 0, 0);
    check("c1_cfg_1", 32'(cfg_log[1]), 32'd1);
    check("c1_cfg_cnt", 32'(n_cfg), 32'd1);
    check("c1_rden_cnt", 32'(n_rden), 32'd0);
    check("c1_done_cnt", 32'(n_done), 32'd0);
    check("c1_busy_cnt", 32'(n_busy), 32'd0);
    do_start(0, 3);
    run_cycles(4, 99, 0, 0);
    check("c2_cfg_cnt", 32'(n_cfg), 32'd1);
    check("c2_rden_cnt", 32'(n_rden), 32'd0);

    // Start pulse during RUN is ignored
    do_start(3, 2);
    run_cycles(12, 99, 0, 3);
    check("d_rden_cnt", 32'(n_rden), 32'd6);
    check("d_done_8", 32'(done_log[8]), 32'd1);
    check("d_done_cnt", 32'(n_done), 32'd1);
    check("d_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in cycle 3 of a job, then a fresh job
    do_start(5, 1);
    run_cycles(2, 99, 0, 0);
    rst = 1'b0;
    #1;
    check("e_rst_rden", 32'(rden), 32'd0);
    check("e_rst_busy", 32'(busy), 32'd0);
    check("e_rst_rdAddr", 32'(rdAddr), 32'd0);
    check("e_rst_valid", 32'(seq_valid), 32'd0);
    check("e_rst_last", 32'(seq_last), 32'd0);
    check("e_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_cycles(6, 99, 0, 0);
    check("e_no_done", 32'(n_done), 32'd0);
    check("e_idle_rden", 32'(n_rden), 32'd0);
    do_start(5, 1);
    run_cycles(9, 99, 0, 0);
    check("e_rden_cnt", 32'(n_rden), 32'd5);
    check("e_done_7", 32'(done_log[7]), 32'd1);
    check("e_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
